// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, flit type codes, port codes and VC state.
package noc_pkg;

  localparam int unsigned DEST_Y_MSB  = 63;
  localparam int unsigned DEST_Y_LSB  = 56;
  localparam int unsigned DEST_X_MSB  = 55;
  localparam int unsigned DEST_X_LSB  = 48;
  localparam int unsigned TYPE_MSB    = 47;
  localparam int unsigned TYPE_LSB    = 45;
  localparam int unsigned PID_MSB     = 44;
  localparam int unsigned PID_LSB     = 40;
  localparam int unsigned PAYLOAD_MSB = 39;
  localparam int unsigned PAYLOAD_LSB = 0;

  typedef logic [2:0] flit_type_t;

  localparam flit_type_t FLIT_HEAD = 3'b000;
  localparam flit_type_t FLIT_BODY = 3'b001;
  localparam flit_type_t FLIT_TAIL = 3'b010;

  localparam logic [1:0] NORTH = 2'b00;
  localparam logic [1:0] EAST  = 2'b01;
  localparam logic [1:0] SOUTH = 2'b10;
  localparam logic [1:0] WEST  = 2'b11;

  typedef enum logic {
    IDLE,
    ACTIVE
  } vc_state_e;

endpackage

// File: rtl/input_vc_buffer_if.sv
// Link-side, route-computation-side and allocator-side signals of one input VC buffer.
interface input_vc_buffer_if #(
  parameter int unsigned FLIT_W = 64,
  parameter int unsigned VC_W   = 1
);
  logic              in_valid;
  logic [VC_W-1:0]   in_vc;
  logic [FLIT_W-1:0] in_flit;
  logic              credit_valid;
  logic [VC_W-1:0]   credit_vc;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic [VC_W-1:0]   out_vc;
  logic              out_is_head;
  logic [3:0]        route_in;
  logic [3:0]        out_route;
  logic              out_ready;
  logic              err;

  modport master (
    output in_valid, in_vc, in_flit, route_in, out_ready,
    input  credit_valid, credit_vc, out_valid, out_flit, out_vc, out_is_head, out_route, err
  );

  modport slave (
    input  in_valid, in_vc, in_flit, route_in, out_ready,
    output credit_valid, credit_vc, out_valid, out_flit, out_vc, out_is_head, out_route, err
  );
endinterface

// File: rtl/input_vc_buffer_flit_fifo.sv
// Synchronous flit FIFO; a push into a full FIFO is only taken when a pop happens the same cycle.
module flit_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// Per-input-port VC buffer: per-VC FIFOs, round-robin head-of-line selection, per-packet route
// latching, credit return and sticky protocol error detection.
module input_vc_buffer
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = 64,
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned DEPTH  = 4
) (
  input logic              clk,
  input logic              rst_n,
  input_vc_buffer_if.slave bus
);
  localparam int unsigned VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_VC-1:0] empty, full, push, pop, nonempty;
  logic [FLIT_W-1:0] dout [NUM_VC];
  logic [CNT_W-1:0]  count [NUM_VC];

  vc_state_e         state_q [NUM_VC];
  vc_state_e         state_d [NUM_VC];
  logic [3:0]        route_q [NUM_VC];
  logic [3:0]        route_d [NUM_VC];
  logic [VC_W-1:0]   rr_q, rr_d, sel, idx, hold_vc_q, credit_vc_q;
  logic              hold_q, found, deq, err_q, err_d, credit_valid_q;
  logic [FLIT_W-1:0] head_flit;
  flit_type_t        head_type;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v]     = bus.in_valid && (bus.in_vc == VC_W'(v));
    assign pop[v]      = deq && (sel == VC_W'(v));
    assign nonempty[v] = (count[v] != '0);

    flit_fifo #(
      .WIDTH(FLIT_W),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[v]),
      .pop  (pop[v]),
      .din  (bus.in_flit),
      .dout (dout[v]),
      .empty(empty[v]),
      .full (full[v]),
      .count(count[v])
    );
  end

  // A stalled flit keeps its VC even if a higher-priority VC fills up meanwhile.
  always_comb begin
    sel   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    if (hold_q) begin
      sel = hold_vc_q;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        idx = VC_W'((32'(rr_q) + 32'(i)) % NUM_VC);
        if (!found && !empty[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign bus.out_valid   = |nonempty;
  assign deq             = bus.out_valid && bus.out_ready;
  assign head_flit       = dout[sel];
  assign head_type       = head_flit[TYPE_MSB:TYPE_LSB];
  assign bus.out_flit    = bus.out_valid ? head_flit : '0;
  assign bus.out_vc      = bus.out_valid ? sel : '0;
  assign bus.out_is_head = bus.out_valid && (head_type == FLIT_HEAD);
  assign bus.out_route   = !bus.out_valid ? 4'b0000 :
                           bus.out_is_head ? bus.route_in : route_q[sel];
  assign bus.credit_valid = credit_valid_q;
  assign bus.credit_vc    = credit_vc_q;
  assign bus.err          = err_q;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    err_d   = err_q;
    rr_d    = rr_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (push[v] && full[v] && !pop[v]) err_d = 1'b1;
    end
    if (deq) begin
      rr_d = VC_W'((32'(sel) + 32'd1) % NUM_VC);
      case (head_type)
        FLIT_HEAD: begin
          if (state_q[sel] == IDLE) begin
            state_d[sel] = ACTIVE;
            route_d[sel] = bus.route_in;
          end else begin
            err_d = 1'b1;
          end
        end
        FLIT_BODY: if (state_q[sel] != ACTIVE) err_d = 1'b1;
        FLIT_TAIL: begin
          if (state_q[sel] == ACTIVE) state_d[sel] = IDLE;
          else err_d = 1'b1;
        end
        default:   err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= IDLE;
        route_q[v] <= 4'b0000;
      end
      rr_q           <= '0;
      hold_q         <= 1'b0;
      hold_vc_q      <= '0;
      err_q          <= 1'b0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      state_q        <= state_d;
      route_q        <= route_d;
      rr_q           <= rr_d;
      hold_q         <= bus.out_valid && !bus.out_ready;
      hold_vc_q      <= sel;
      err_q          <= err_d;
      credit_valid_q <= deq;
      credit_vc_q    <= sel;
    end
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer: packet flow, interleave, stall, overflow, protocol errors
// and mid-packet reset.
module tb_input_vc_buffer;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  input_vc_buffer_if #(.FLIT_W(64), .VC_W(1)) bus ();

  input_vc_buffer #(
    .FLIT_W(64),
    .NUM_VC(2),
    .DEPTH (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] mk(input logic [2:0] t, input logic [4:0] pid,
                                     input logic [39:0] pl);
    return {8'd1, 8'd0, t, pid, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic vc, input logic [63:0] f);
    bus.in_valid = 1'b1;
    bus.in_vc    = vc;
    bus.in_flit  = f;
  endtask

  task automatic no_push();
    bus.in_valid = 1'b0;
    bus.in_vc    = 1'b0;
    bus.in_flit  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_flit"}, bus.out_flit, 64'd0);
    chk({tag, "_vc"}, 64'(bus.out_vc), 64'd0);
    chk({tag, "_head"}, 64'(bus.out_is_head), 64'd0);
    chk({tag, "_route"}, 64'(bus.out_route), 64'd0);
    chk({tag, "_cv"}, 64'(bus.credit_valid), 64'd0);
    chk({tag, "_cvc"}, 64'(bus.credit_vc), 64'd0);
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
  endtask

  logic [63:0] f2 [6];
  logic [63:0] f3 [4];
  logic [63:0] f3_drop, f3_first;

  initial begin
    no_push();
    bus.out_ready = 1'b0;
    bus.route_in  = 4'b0000;

    // Reset state
    tick();
    tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Single packet on VC0
    bus.out_ready = 1'b1;
    push(1'b0, mk(FLIT_HEAD, 5'd1, 40'h11));
    chk("s1_valid0", 64'(bus.out_valid), 64'd0);
    tick();
    push(1'b0, mk(FLIT_BODY, 5'd1, 40'h12));
    chk("s1_valid1", 64'(bus.out_valid), 64'd1);
    chk("s1_hflit", bus.out_flit, mk(FLIT_HEAD, 5'd1, 40'h11));
    chk("s1_hhead", 64'(bus.out_is_head), 64'd1);
    chk("s1_hroute", 64'(bus.out_route), 64'd0);
    tick();
    push(1'b0, mk(FLIT_TAIL, 5'd1, 40'h13));
    bus.route_in = 4'hF;
    chk("s1_bflit", bus.out_flit, mk(FLIT_BODY, 5'd1, 40'h12));
    chk("s1_bhead", 64'(bus.out_is_head), 64'd0);
    chk("s1_broute", 64'(bus.out_route), 64'd0);
    chk("s1_cv1", 64'(bus.credit_valid), 64'd1);
    chk("s1_cvc1", 64'(bus.credit_vc), 64'd0);
    tick();
    no_push();
    chk("s1_tflit", bus.out_flit, mk(FLIT_TAIL, 5'd1, 40'h13));
    chk("s1_troute", 64'(bus.out_route), 64'd0);
    chk("s1_cv2", 64'(bus.credit_valid), 64'd1);
    tick();
    chk("s1_empty", 64'(bus.out_valid), 64'd0);
    chk("s1_cv3", 64'(bus.credit_valid), 64'd1);
    chk("s1_cvc3", 64'(bus.credit_vc), 64'd0);
    chk("s1_err", 64'(bus.err), 64'd0);
    tick();
    chk("s1_cv_end", 64'(bus.credit_valid), 64'd0);

    // Interleave two packets, with a 5-cycle stall once both are buffered
    bus.out_ready = 1'b0;
    bus.route_in  = 4'b0000;
    f2[0] = mk(FLIT_HEAD, 5'd2, 40'h20);
    f2[1] = mk(FLIT_HEAD, 5'd3, 40'h30);
    f2[2] = mk(FLIT_BODY, 5'd2, 40'h21);
    f2[3] = mk(FLIT_BODY, 5'd3, 40'h31);
    f2[4] = mk(FLIT_TAIL, 5'd2, 40'h22);
    f2[5] = mk(FLIT_TAIL, 5'd3, 40'h32);
    for (int i = 0; i < 6; i++) begin
      push(1'(i % 2), f2[i]);
      tick();
    end
    no_push();
    for (int i = 0; i < 5; i++) begin
      chk("stall_vc", 64'(bus.out_vc), 64'd0);
      chk("stall_flit", bus.out_flit, f2[0]);
      chk("stall_cv", 64'(bus.credit_valid), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.route_in = (i == 0) ? 4'b1100 : (i == 1) ? 4'b0101 : 4'b0011;
      #1;
      chk("il_vc", 64'(bus.out_vc), 64'(i % 2));
      chk("il_flit", bus.out_flit, f2[i]);
      chk("il_route", 64'(bus.out_route), (i % 2 == 1) ? 64'h5 : 64'hC);
      if (i > 0) begin
        chk("il_cv", 64'(bus.credit_valid), 64'd1);
        chk("il_cvc", 64'(bus.credit_vc), 64'((i - 1) % 2));
      end
      tick();
    end
    chk("il_empty", 64'(bus.out_valid), 64'd0);
    chk("il_cv_last", 64'(bus.credit_valid), 64'd1);
    chk("il_cvc_last", 64'(bus.credit_vc), 64'd1);
    chk("il_err", 64'(bus.err), 64'd0);

    // Full boundary on VC1
    bus.out_ready = 1'b0;
    bus.route_in  = 4'b0000;
    f3_first = mk(FLIT_HEAD, 5'd4, 40'h41);
    f3[0] = mk(FLIT_BODY, 5'd4, 40'h42);
    f3[1] = mk(FLIT_BODY, 5'd4, 40'h43);
    f3[2] = mk(FLIT_BODY, 5'd4, 40'h44);
    f3[3] = mk(FLIT_TAIL, 5'd4, 40'h46);
    f3_drop = mk(FLIT_BODY, 5'd4, 40'h45);
    push(1'b1, f3_first);
    tick();
    for (int i = 0; i < 3; i++) begin
      push(1'b1, f3[i]);
      tick();
    end
    no_push();
    chk("full_err0", 64'(bus.err), 64'd0);
    push(1'b1, f3_drop);
    tick();
    no_push();
    chk("ovf_err", 64'(bus.err), 64'd1);
    chk("ovf_head", bus.out_flit, f3_first);
    chk("ovf_vc", 64'(bus.out_vc), 64'd1);
    push(1'b1, f3[3]);
    bus.out_ready = 1'b1;
    bus.route_in  = 4'b1001;
    tick();
    no_push();
    bus.route_in = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_flit", bus.out_flit, f3[i]);
      chk("full_route", 64'(bus.out_route), 64'h9);
      chk("full_cv", 64'(bus.credit_valid), 64'd1);
      chk("full_cvc", 64'(bus.credit_vc), 64'd1);
      tick();
    end
    chk("full_empty", 64'(bus.out_valid), 64'd0);
    chk("full_err_sticky", 64'(bus.err), 64'd1);

    // Reset clears the sticky error
    rst_n = 1'b0;
    #2;
    chk("rst2_err", 64'(bus.err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Protocol errors on VC0
    bus.out_ready = 1'b1;
    bus.route_in  = 4'b0000;
    push(1'b0, mk(FLIT_BODY, 5'd5, 40'h51));
    tick();
    push(1'b0, mk(FLIT_HEAD, 5'd6, 40'h61));
    chk("pe_err_pre", 64'(bus.err), 64'd0);
    tick();
    push(1'b0, mk(FLIT_HEAD, 5'd7, 40'h71));
    chk("pe_err1", 64'(bus.err), 64'd1);
    chk("pe_flit2", bus.out_flit, mk(FLIT_HEAD, 5'd6, 40'h61));
    chk("pe_cv1", 64'(bus.credit_valid), 64'd1);
    tick();
    push(1'b0, mk(3'b101, 5'd8, 40'h81));
    chk("pe_flit3", bus.out_flit, mk(FLIT_HEAD, 5'd7, 40'h71));
    chk("pe_cv2", 64'(bus.credit_valid), 64'd1);
    tick();
    no_push();
    chk("pe_flit4", bus.out_flit, mk(3'b101, 5'd8, 40'h81));
    chk("pe_cv3", 64'(bus.credit_valid), 64'd1);
    tick();
    chk("pe_empty", 64'(bus.out_valid), 64'd0);
    chk("pe_cv4", 64'(bus.credit_valid), 64'd1);
    chk("pe_err_end", 64'(bus.err), 64'd1);
    tick();
    chk("pe_cv_end", 64'(bus.credit_valid), 64'd0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Mid-packet reset
    push(1'b0, mk(FLIT_HEAD, 5'd9, 40'h91));
    tick();
    push(1'b0, mk(FLIT_BODY, 5'd9, 40'h92));
    tick();
    push(1'b0, mk(FLIT_TAIL, 5'd9, 40'h93));
    tick();
    no_push();
    chk("mr_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mr");
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_post_valid", 64'(bus.out_valid), 64'd0);
    push(1'b0, mk(FLIT_HEAD, 5'd10, 40'hA1));
    bus.route_in = 4'b0110;
    tick();
    no_push();
    chk("mr_new_flit", bus.out_flit, mk(FLIT_HEAD, 5'd10, 40'hA1));
    chk("mr_new_head", 64'(bus.out_is_head), 64'd1);
    chk("mr_new_route", 64'(bus.out_route), 64'h6);
    tick();
    chk("mr_new_err", 64'(bus.err), 64'd0);
    chk("mr_new_cv", 64'(bus.credit_valid), 64'd1);
    chk("mr_new_empty", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_vc_buffer.md
Name: input_vc_buffer

Overview:
Per-input-port virtual-channel buffer. It sits directly upstream of the route computation unit and directly downstream of the link from the neighbouring router. It stores incoming 64-bit flits in one FIFO per VC and presents one head-of-line flit per cycle on the port's route-computation input. It latches the route returned for each HEAD flit so that BODY and TAIL flits of the same packet reuse that route, and it returns credits upstream.

Parameters:
FLIT_W, 64, flit width; field layout is fixed: [63:56] dest Y, [55:48] dest X, [47:45] type, [44:40] packet ID, [39:0] payload
NUM_VC, 2, virtual channels per port; VC index width is 1
DEPTH, 4, flits per VC FIFO; must be a power of 2 and at least 2

Ports:
clk  input  1  router clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  flit arriving from upstream link this cycle
in_vc  input  1  target VC of the arriving flit
in_flit  input  FLIT_W  arriving flit
credit_valid  output  1  one-cycle credit pulse to upstream
credit_vc  output  1  VC the credit belongs to
out_valid  output  1  head-of-line flit presented
out_flit  output  FLIT_W  presented flit; feeds the route-computation input for this port
out_vc  output  1  VC of the presented flit
out_is_head  output  1  out_flit type field equals 3'b000
route_in  input  4  route returned by route computation: [3:2] port, [1:0] VC
out_route  output  4  route_in when out_is_head, otherwise the stored route of out_vc
out_ready  input  1  switch allocator accepts the presented flit this cycle
err  output  1  sticky protocol error flag; cleared only by reset

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All FIFOs are empty and all VC states are IDLE.
  - The round-robin pointer is VC0.
  - Stored routes are 4'b0000.
  - Outputs: out_valid=0, out_flit=0, out_vc=0, out_is_head=0, out_route=0, credit_valid=0, credit_vc=0, err=0.
  - Reset during a packet discards all buffered flits. No credits are issued for discarded flits.
- Enqueue:
  - When in_valid=1, in_flit is written to FIFO[in_vc] at the clock edge.
  - Enqueue-to-visible latency is 1 cycle. A flit written into an empty FIFO is presented no earlier than the next cycle.
- Presentation:
  - out_valid=1 whenever any FIFO is non-empty.
  - The presented VC is chosen by round-robin among non-empty VCs, starting at the pointer.
  - out_flit, out_vc, out_is_head and out_route are combinational from the selected FIFO head and the stored route.
- Dequeue:
  - Occurs when out_valid && out_ready. The selected FIFO pops at the clock edge.
  - The round-robin pointer moves to (out_vc+1) mod NUM_VC, so VCs interleave at flit granularity.
  - Without out_ready the selection is held stable. The VC does not change while a flit is stalled.
- Credits: one cycle after each dequeue, credit_valid=1 for exactly one cycle with credit_vc equal to the dequeued VC. At most one credit is issued per cycle.
- Per-VC state machine:
  - IDLE to ACTIVE on dequeue of a HEAD flit (type 000). route_in is captured into route_reg[vc].
  - ACTIVE to ACTIVE on dequeue of a BODY flit (type 001). route_reg is unchanged.
  - ACTIVE to IDLE on dequeue of a TAIL flit (type 010). route_reg is retained until the next head overwrites it.
- Protocol errors: each sets err=1 (sticky). The flit is still dequeued, its credit is still returned, and the state is unchanged.
  - HEAD dequeued while the VC is ACTIVE.
  - BODY or TAIL dequeued while the VC is IDLE.
  - Type field 011 to 111.
- Overflow: in_valid to a VC whose FIFO is full with no same-cycle pop on that VC.
  - The flit is dropped and err=1.
  - A full FIFO with a same-cycle pop and push on the same VC accepts the push; the count is unchanged.
- Pointers and counts:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits.
  - Empty is count==0; full is count==DEPTH.
- Simultaneous events: a push to one VC and a pop from another VC in the same cycle are independent.

Decomposition:
- Shared package noc_pkg holds:
  - Flit field bit positions.
  - Flit type constants: FLIT_HEAD=3'b000, FLIT_BODY=3'b001, FLIT_TAIL=3'b010.
  - Port codes: NORTH=2'b00, EAST=2'b01, SOUTH=2'b10, WEST=2'b11.
  - VC state enum: IDLE, ACTIVE.
- One sub-module, flit_fifo: synchronous FIFO with push, pop, dout, empty, full and count. It is instantiated NUM_VC times. The VC state machines, arbitration, route registers and credit logic stay in input_vc_buffer.

Test Plan:
- Reset then single packet. Push HEAD (Y=1, X=0), BODY, TAIL on VC0 in consecutive cycles; out_ready=1; route_in=4'b0000 during the head.
  - out_valid rises 1 cycle after the first push.
  - out_route is 4'b0000 on all three flits.
  - Three credit pulses on VC0, each 1 cycle after its dequeue.
  - VC0 state returns to IDLE; err=0.
- Interleave. Packets on VC0 and VC1, each 3 flits, fully enqueued; then out_ready=1.
  - out_vc sequence is 0,1,0,1,0,1.
  - Each body/tail carries its own VC's captured route (VC0 captures route_in=4'b1100, VC1 captures 4'b0101).
- Stall. out_ready=0 for 5 cycles with both VCs non-empty.
  - out_flit and out_vc are stable for all 5 cycles.
  - No credits are issued.
- Full boundary. Push DEPTH=4 flits to VC1 with out_ready=0, then push a 5th.
  - The 5th flit is dropped and err=1.
  - The next dequeue returns flit 1.
  - A push and pop in the same cycle on a full FIFO keeps the count at 4.
- Protocol errors. BODY with no preceding HEAD, then HEAD while ACTIVE, then type 3'b101.
  - err=1 from the first violation and stays 1.
  - All three flits are dequeued and credited.
- Mid-packet reset. Assert rst_n=0 after HEAD and BODY have been dequeued.
  - All outputs are 0 immediately.
  - After release, out_valid=0 and a fresh HEAD is accepted with err=0.
